// File: rtl/emu_rst_ctrl.sv
// Reset, PLL-lock and switch conditioning for the emulator top level.
// Synchronises raw board inputs, debounces switches and sequences the DUT reset.
module emu_rst_ctrl #(
    parameter int NUM_SW          = 2,
    parameter int SOFT_RST_IDX    = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int LOCK_FILTER     = 16,
    parameter int RST_HOLD        = 32,
    parameter int BLINK_W         = 22
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              pll_lock_i,
    input  logic [NUM_SW-1:0] switch_i,
    input  logic              error_i,
    output logic [NUM_SW-1:0] switch_o,
    output logic              rst_n_o,
    output logic [1:0]        state_o,
    output logic [7:0]        lock_loss_cnt_o,
    output logic [2:0]        led_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LF_W = $clog2(LOCK_FILTER + 1);
    localparam int RH_W = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]             lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0][NUM_SW-1:0] sw_sync_q, sw_sync_d;
    logic [NUM_SW-1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [NUM_SW-1:0]                  sw_db_q, sw_db_d;
    logic                               soft_prev_q, soft_prev_d;
    state_t                             state_q, state_d;
    logic [LF_W-1:0]                    lock_cnt_q, lock_cnt_d;
    logic [RH_W-1:0]                    hold_cnt_q, hold_cnt_d;
    logic [7:0]                         loss_cnt_q, loss_cnt_d;
    logic                               rst_n_q, rst_n_d;
    logic                               err_q, err_d;
    logic [BLINK_W-1:0]                 blink_q, blink_d;

    logic              lock_s;
    logic [NUM_SW-1:0] sw_s;
    logic              soft_rise;

    assign lock_s    = lock_sync_q[SYNC_STAGES-1];
    assign sw_s      = sw_sync_q[SYNC_STAGES-1];
    assign soft_rise = sw_db_q[SOFT_RST_IDX] & ~soft_prev_q;

    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_lock_i};
        sw_sync_d   = {sw_sync_q[SYNC_STAGES-2:0], switch_i};
        soft_prev_d = sw_db_q[SOFT_RST_IDX];
        err_d       = err_q | error_i;
        blink_d     = blink_q + BLINK_W'(1);
    end

    // A channel only flips after its synced level has disagreed for a full window.
    always_comb begin
        db_cnt_d = db_cnt_q;
        sw_db_d  = sw_db_q;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sw_s[i] == sw_db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                sw_db_d[i]  = sw_s[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Lock loss is checked before the soft-reset edge so it always wins.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        hold_cnt_d = hold_cnt_q;
        loss_cnt_d = loss_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                hold_cnt_d = '0;
                if (!lock_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LF_W'(LOCK_FILTER - 1)) begin
                    state_d    = HOLD;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LF_W'(1);
                end
            end
            HOLD: begin
                lock_cnt_d = '0;
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == RH_W'(RST_HOLD - 1)) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + RH_W'(1);
                end
            end
            RUN: begin
                lock_cnt_d = '0;
                hold_cnt_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end else if (soft_rise) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase
        rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            lock_sync_q <= '0;
            sw_sync_q   <= '0;
            db_cnt_q    <= '0;
            sw_db_q     <= '0;
            soft_prev_q <= 1'b0;
            state_q     <= WAIT_LOCK;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            loss_cnt_q  <= '0;
            rst_n_q     <= 1'b0;
            err_q       <= 1'b0;
            blink_q     <= '0;
        end else begin
            lock_sync_q <= lock_sync_d;
            sw_sync_q   <= sw_sync_d;
            db_cnt_q    <= db_cnt_d;
            sw_db_q     <= sw_db_d;
            soft_prev_q <= soft_prev_d;
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            rst_n_q     <= rst_n_d;
            err_q       <= err_d;
            blink_q     <= blink_d;
        end
    end

    assign switch_o        = sw_db_q;
    assign rst_n_o         = rst_n_q;
    assign state_o         = state_q;
    assign lock_loss_cnt_o = loss_cnt_q;
    assign led_o           = {err_q, (state_q == RUN) ? 1'b1 : blink_q[BLINK_W-1], ~rst_n_q};

endmodule
